uart_rx_core: RTL and testbench
===============================

UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter DATA_BITS, default 8, SHALL set data bits per frame; legal range 5..9.
REQ-002 Parameter OVERSAMPLE, default 16, SHALL set oversample ticks per bit; legal values even, >= 4.
REQ-003 Parameter DIV_W, default 16, SHALL set the width of baud_div.
REQ-004 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 reset  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 rx_en  in  1  SHALL enable reception.
REQ-007 rx_in  in  1  SHALL be the asynchronous serial line; idle high.
REQ-008 baud_div  in  DIV_W  SHALL give clocks per oversample tick minus 1.
REQ-009 parity_mode  in  2  SHALL select parity: 00 none, 01 even, 10 odd, 11 none.
REQ-010 stop2  in  1  SHALL select two stop bits when 1 and one stop bit when 0.
REQ-011 data_out  out  DATA_BITS  SHALL hold the received word.
REQ-012 valid_out  out  1  SHALL flag that data_out, parity_err and frame_err are valid.
REQ-013 ready_in  in  1  SHALL be the consumer accept signal.
REQ-014 parity_err, frame_err  out  1 each  SHALL be error flags qualifying data_out.
REQ-015 overrun  out  1  SHALL be a sticky flag for a lost frame.
REQ-016 busy  out  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-017 rx_in SHALL pass through a 2-flop synchronizer (reset value 1) before any use.
REQ-018 Tick generator: counter runs 0..baud_div and pulses tick for one clk when count==baud_div, then wraps to 0; baud_div=0 gives a tick every clk.
REQ-019 The tick counter and oversample counter SHALL clear on entry to START.
REQ-020 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-021 IDLE->START: rx_en=1 and synchronized rx low.
REQ-022 START: after OVERSAMPLE/2 ticks, sample rx; if high, return to IDLE with no flags (glitch reject); if low, go to DATA.
REQ-023 DATA: sample every OVERSAMPLE ticks, LSB first, into the shift register; after DATA_BITS samples, go to PARITY if parity is enabled, else STOP.
REQ-024 PARITY: sample one bit; the error condition is XOR(data, parity bit)=1 for even parity and =0 for odd parity.
REQ-025 STOP: sample one stop bit, or two if stop2=1; frame_err SHALL be set if any sampled stop bit is 0.
REQ-026 After the final stop-bit sample (mid-bit), the FSM SHALL return to IDLE at once so the next start edge is caught.
REQ-027 Frame completion SHALL load data_out and both error flags and set valid_out on the next clk.
REQ-028 valid_out SHALL stay high, with data_out and flags stable, until a cycle with valid_out&&ready_in; it clears on the following clk.
REQ-029 If a frame completes while valid_out=1 and ready_in=0, overrun SHALL be set, the new frame dropped, and the held data kept.
REQ-030 If a frame completes in the same cycle as an accepting handshake, overrun SHALL NOT be set and the new frame SHALL be loaded.
REQ-031 overrun SHALL clear only on reset or when rx_en=0.
REQ-032 If rx_en goes to 0 mid-frame, the FSM SHALL enter IDLE on the next clk and discard the partial frame; the held output and valid_out SHALL be unaffected.
REQ-033 Changes to baud_div, parity_mode or stop2 SHALL take effect only when the FSM is in IDLE; they are latched on the IDLE->START transition.

Reset
REQ-034 While reset=0: FSM IDLE, all counters 0, data_out=0, valid_out=0, parity_err=0, frame_err=0, overrun=0, busy=0.
REQ-035 Reset asserted mid-frame SHALL abort the frame immediately; no valid_out SHALL follow reset release.

Verification
REQ-036 baud_div=3, OVERSAMPLE=16, even parity, 1 stop bit, send 0xA5 with correct parity, ready_in=1 -> data_out=0xA5, valid_out for 1 clk, parity_err=0, frame_err=0.
REQ-037 Odd parity, send 0x3C with the parity bit inverted -> data_out=0x3C, parity_err=1.
REQ-038 stop2=1, send 0x55 with the second stop bit = 0 -> frame_err=1, FSM back in IDLE.
REQ-039 rx_in low for 20 clks (< 32-clk half-bit) -> no valid_out, busy returns to 0.
REQ-040 Send 0x11 then 0x22 with ready_in=0 -> data_out=0x11, overrun=1; then pulse ready_in -> valid_out=0, overrun stays 1 until rx_en=0.
REQ-041 reset=0 during data bit 4 of a frame -> all outputs 0; after release, a clean 0x81 frame is received correctly.

Source files
------------

// File: rtl/uart_rx_core_if.sv
// Receive-side output handshake of uart_rx_core.
// valid/ready: the producer raises valid_out together with data_out,
// parity_err and frame_err and holds all of them stable until a rising clk
// edge where valid_out && ready_in; the word transfers on that edge and
// valid_out may only fall after it.
interface uart_rx_core_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 valid_out;
  logic                 ready_in;
  logic                 parity_err;
  logic                 frame_err;

  modport master (
    output data_out,
    output valid_out,
    output parity_err,
    output frame_err,
    input  ready_in
  );

  modport slave (
    input  data_out,
    input  valid_out,
    input  parity_err,
    input  frame_err,
    output ready_in
  );
endinterface

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: 2-flop line synchronizer, programmable tick
// generator, IDLE/START/DATA/PARITY/STOP frame FSM and a one-deep held
// output word with a sticky overrun flag.
module uart_rx_core #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_en,
  input  logic             rx_in,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       parity_mode,
  input  logic             stop2,
  output logic             overrun,
  output logic             busy,
  output logic [2:0]       state_dbg,
  uart_rx_core_if.master   out_if
);
  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam int BC_W = $clog2(DATA_BITS + 1);
  localparam logic [OS_W-1:0] HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] FULL_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] DATA_LAST = BC_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_sync_q;
  logic [DIV_W-1:0]     div_q, div_d, tick_cnt_q, tick_cnt_d;
  logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
  logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           pmode_q, pmode_d;
  logic                 stop2_q, stop2_d;
  logic                 par_err_q, par_err_d;
  logic                 stop_err_q, stop_err_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 overrun_q, overrun_d;
  logic                 tick, sample, par_en, frame_done;

  // Sample points: half a bit into the start bit, then one full bit apart.
  assign tick       = (tick_cnt_q == div_q);
  assign sample     = (state_q != S_IDLE) && tick &&
                      (os_cnt_q == ((state_q == S_START) ? HALF_LAST : FULL_LAST));
  assign par_en     = (pmode_q == 2'b01) || (pmode_q == 2'b10);
  assign frame_done = rx_en && (state_q == S_STOP) && sample &&
                      (!stop2_q || (bit_cnt_q != '0));

  // Two-flop synchronizer for the asynchronous serial line, idle high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_in;
      rx_sync_q <= rx_meta_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; dropping rx_en abandons any frame in progress.
  always_comb begin
    state_d = state_q;
    if (!rx_en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (!rx_sync_q) state_d = S_START;
        S_START:  if (sample) state_d = rx_sync_q ? S_IDLE : S_DATA;
        S_DATA:   if (sample && (bit_cnt_q == DATA_LAST)) state_d = par_en ? S_PARITY : S_STOP;
        S_PARITY: if (sample) state_d = S_STOP;
        S_STOP:   if (frame_done) state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    busy      = (state_q != S_IDLE);
    state_dbg = state_q;
  end

  // Frame datapath: counters, shift register, per-frame error flags and
  // configuration latched as the FSM leaves IDLE.
  always_comb begin
    div_d      = div_q;
    pmode_d    = pmode_q;
    stop2_d    = stop2_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + DIV_W'(1);
    os_cnt_d   = sample ? '0 : (tick ? os_cnt_q + OS_W'(1) : os_cnt_q);
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    stop_err_d = stop_err_q;
    if (state_q == S_IDLE) begin
      tick_cnt_d = '0;
      os_cnt_d   = '0;
      bit_cnt_d  = '0;
      if (state_d == S_START) begin
        div_d      = baud_div;
        pmode_d    = parity_mode;
        stop2_d    = stop2;
        par_err_d  = 1'b0;
        stop_err_d = 1'b0;
      end
    end else if (sample) begin
      case (state_q)
        S_DATA: begin
          shift_d   = {rx_sync_q, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = (bit_cnt_q == DATA_LAST) ? '0 : bit_cnt_q + BC_W'(1);
        end
        S_PARITY: begin
          par_err_d = (pmode_q == 2'b01) ? (^shift_q ^ rx_sync_q) : ~(^shift_q ^ rx_sync_q);
        end
        S_STOP: begin
          if (!rx_sync_q) stop_err_d = 1'b1;
          bit_cnt_d = bit_cnt_q + BC_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Frame datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q      <= '0;
      pmode_q    <= 2'b00;
      stop2_q    <= 1'b0;
      tick_cnt_q <= '0;
      os_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      pmode_q    <= pmode_d;
      stop2_q    <= stop2_d;
      tick_cnt_q <= tick_cnt_d;
      os_cnt_q   <= os_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_err_q  <= par_err_d;
      stop_err_q <= stop_err_d;
    end
  end

  // Held output word: a completed frame loads unless an unaccepted word is
  // still held, in which case it is dropped and overrun latches.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    overrun_d = overrun_q;
    if (valid_q && out_if.ready_in) valid_d = 1'b0;
    if (frame_done) begin
      if (valid_q && !out_if.ready_in) begin
        overrun_d = 1'b1;
      end else begin
        data_d  = shift_q;
        perr_d  = par_err_q;
        ferr_d  = stop_err_d;
        valid_d = 1'b1;
      end
    end
    if (!rx_en) overrun_d = 1'b0;
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_if.data_out   = data_q;
  assign out_if.valid_out  = valid_q;
  assign out_if.parity_err = perr_q;
  assign out_if.frame_err  = ferr_q;
  assign overrun           = overrun_q;
endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed frames, glitch, overrun and reset cases
// plus randomized frames, checked by an expected-word queue and monitor.
module tb_uart_rx_core;
  localparam int DB = 8;

  logic        clk = 1'b0;
  logic        reset, rx_en, rx_in, stop2;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        overrun, busy;
  logic [2:0]  state_dbg;

  int             tests_run = 0;
  int             fails = 0;
  logic [DB+1:0]  exp_q[$];
  bit             ready_mode = 1'b0;
  logic           ready_manual = 1'b1;
  bit             hs_prev = 1'b0;

  uart_rx_core_if #(.DATA_BITS(DB)) rx_if ();

  uart_rx_core #(.DATA_BITS(DB), .OVERSAMPLE(16), .DIV_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_en       (rx_en),
    .rx_in       (rx_in),
    .baud_div    (baud_div),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .overrun     (overrun),
    .busy        (busy),
    .state_dbg   (state_dbg),
    .out_if      (rx_if.master)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests_run++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  // Realign to just after a rising edge before driving.
  task automatic sync_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_line(input logic b, input int n);
    rx_in = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One serial frame. The expected word is queued before the start bit
  // because the receiver presents it halfway through the last stop bit.
  task automatic send_frame(input logic [DB-1:0] d, input logic [1:0] pm, input logic s2,
                            input bit flip_par, input bit bad_stop, input bit push);
    int   bp;
    logic pbit;
    logic perr_e;
    bp = (int'(baud_div) + 1) * 16;
    parity_mode = pm;
    stop2 = s2;
    perr_e = ((pm == 2'b01) || (pm == 2'b10)) && flip_par;
    if (push) exp_q.push_back({perr_e, bad_stop, d});
    hold_line(1'b1, bp);
    hold_line(1'b0, bp);
    for (int i = 0; i < DB; i++) hold_line(d[i], bp);
    if ((pm == 2'b01) || (pm == 2'b10)) begin
      pbit = (pm == 2'b01) ? ^d : ~^d;
      hold_line(pbit ^ flip_par, bp);
    end
    if (s2) hold_line(1'b1, bp);
    if (bad_stop) begin
      hold_line(1'b0, bp * 3 / 4);
      hold_line(1'b1, bp - bp * 3 / 4);
    end else begin
      hold_line(1'b1, bp);
    end
    hold_line(1'b1, bp);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, rx_if.valid_out, 0);
    check({tag, "_data"}, rx_if.data_out, 0);
    check({tag, "_perr"}, rx_if.parity_err, 0);
    check({tag, "_ferr"}, rx_if.frame_err, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Consumer ready driver.
  initial begin
    rx_if.ready_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rx_if.ready_in = ready_mode ? ($urandom_range(0, 3) != 0) : ready_manual;
    end
  end

  // Monitor: every accepted word is compared with the oldest expected one,
  // and valid_out must drop on the edge that accepts it.
  initial begin
    logic [DB+1:0] act, exp_w;
    forever begin
      @(negedge clk);
      if (hs_prev) check("valid_one_clk", rx_if.valid_out, 0);
      hs_prev = 1'b0;
      if (reset && rx_if.valid_out && rx_if.ready_in) begin
        hs_prev = 1'b1;
        act = {rx_if.parity_err, rx_if.frame_err, rx_if.data_out};
        if (exp_q.size() == 0) begin
          tests_run++;
          fails++;
          $display("FAIL unexpected_word: got 0x%0h, none expected", act);
        end else begin
          exp_w = exp_q.pop_front();
          check("rx_word", act, exp_w);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    int bp;
    reset = 1'b0;
    rx_en = 1'b1;
    rx_in = 1'b1;
    baud_div = 16'd3;
    parity_mode = 2'b00;
    stop2 = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    sync_drive();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // 0xA5, even parity, one stop bit, ready held high.
    send_frame(8'hA5, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    // 0x3C, odd parity with the parity bit inverted.
    send_frame(8'h3C, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1);
    // 0x55, two stop bits, the second one low.
    send_frame(8'h55, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("stop2_err_busy", busy, 0);
    check("stop2_err_state", state_dbg, 0);

    // Short low glitch: START is entered, then rejected with no word.
    sync_drive();
    hold_line(1'b0, 20);
    @(negedge clk);
    check("glitch_busy_high", busy, 1);
    sync_drive();
    hold_line(1'b1, 64);
    @(negedge clk);
    check("glitch_busy_low", busy, 0);
    check("glitch_no_valid", rx_if.valid_out, 0);
    sync_drive();

    // Randomized frames with a randomly stalling consumer.
    ready_mode = 1'b1;
    for (int n = 0; n < 24; n++) begin
      baud_div = 16'($urandom_range(0, 3));
      send_frame(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1'b1);
    end
    ready_mode = 1'b0;
    ready_manual = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    // Overrun: second word arrives while the first is still held.
    baud_div = 16'd3;
    ready_manual = 1'b0;
    sync_drive();
    send_frame(8'h11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("ovr_data_held", rx_if.data_out, 8'h11);
    check("ovr_valid_held", rx_if.valid_out, 1);
    check("ovr_flag_set", overrun, 1);
    ready_manual = 1'b1;
    @(negedge clk);
    ready_manual = 1'b0;
    @(negedge clk);
    check("ovr_valid_cleared", rx_if.valid_out, 0);
    check("ovr_flag_sticky", overrun, 1);
    sync_drive();
    rx_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("ovr_flag_cleared", overrun, 0);
    sync_drive();
    rx_en = 1'b1;
    ready_manual = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Reset in the middle of data bit 4, then a clean 0x81 frame.
    bp = (int'(baud_div) + 1) * 16;
    fork
      send_frame(8'h81, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      begin
        repeat (bp * 6 + bp / 2) @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        check_cleared("midreset");
      end
    join
    sync_drive();
    reset = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("post_reset_no_valid", rx_if.valid_out, 0);
    check("post_reset_busy", busy, 0);
    sync_drive();
    send_frame(8'h81, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
